result_browser: RTL
===================

# result_browser

Post-execution result viewer. It sits between data memory and the 7-segment scan driver. Once the CPU signals completion, it takes over the memory read port and fetches result words one at a time: word 0 is fetched automatically, and later words are fetched on debounced next/prev button presses. The low 16 bits of the current word go to the scan driver as four BCD/hex nibbles.

## Interface
- `BASE_ADDR`, default 32'h00000004: byte address of result word 0.
- `NUM_WORDS`, default 16: number of browsable words, ≥2. `IDX_W` = clog2(`NUM_WORDS`).
- `MEM_LATENCY`, default 1: cycles from `mem_rd_en` to valid `mem_rd_data`, ≥1.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples needed to accept a button level change, ≥2.
- `clk` in 1: system clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `done` in 1: CPU finished execution; same clock domain; level.
- `btn_next` in 1: raw asynchronous push-button, active-high.
- `btn_prev` in 1: raw asynchronous push-button, active-high.
- `mem_rd_data` in 32: data memory read data.
- `mem_rd_en` out 1: single-cycle read strobe.
- `mem_addr` out 32: read address.
- `sel_active` out 1: high once browsing has started. Top-level muxes the memory address onto `mem_addr` when this is high.
- `disp_value` out 16: `{count1, count2, count3, count4}` for the scan driver.
- `disp_valid` out 1: `disp_value` holds fetched data.
- `cur_index` out `IDX_W`: index of the displayed word.

## Operation
- Button path, identical and independent per button:
  - 2-FF synchronizer.
  - Debouncer: counter clears whenever the synced level equals the debounced level. Otherwise it increments. When it reaches `DEBOUNCE_CYCLES`−1 with the level still differing, the debounced level takes the new value and the counter clears.
  - Rising-edge detector on the debounced level gives a one-cycle pulse.
- FSM states: IDLE, FETCH, WAIT, SHOW.
  - IDLE: wait for `done`=1, then go to FETCH with index 0. Set `sel_active`=1 at the same edge.
  - FETCH: `mem_rd_en`=1 for exactly one cycle, `mem_addr`=`BASE_ADDR`+4·index. Go to WAIT.
  - WAIT: count `MEM_LATENCY` cycles. On the edge ending the last one, capture `mem_rd_data[15:0]` into `disp_value`, set `disp_valid`=1, update `cur_index`, and go to SHOW.
  - SHOW: on a next pulse only, index+1, wrapping `NUM_WORDS`−1 → 0, then go to FETCH. On a prev pulse only, index−1, wrapping 0 → `NUM_WORDS`−1, then go to FETCH.
- Button pulses in IDLE, FETCH or WAIT are dropped, not queued.
- Simultaneous next and prev pulses in the same cycle are ignored.
- `done` is latched once accepted. Deassertion afterwards has no effect; only `reset` returns the block to IDLE.
- `mem_addr` holds its value between fetches. `disp_value` keeps the previous word during a refetch. `disp_valid` never drops after the first load.
- Address arithmetic is 32-bit unsigned, with index×4 computed by a 2-bit shift.

## Timing
- Reset values, applied immediately and asynchronously, including mid-fetch:
  - state IDLE.
  - `mem_rd_en`=0, `mem_addr`=0, `sel_active`=0.
  - `disp_value`=0, `disp_valid`=0, `cur_index`=0.
  - Synchronizers, debounced levels and counters all 0.
- `done` high before edge E: `mem_rd_en` is high in cycle E..E+1, and `disp_valid`/`disp_value` are updated after edge E+1+`MEM_LATENCY`.
- Button raw high, first sampled at edge e0 and held:
  - Debounced level rises at edge e0+1+`DEBOUNCE_CYCLES`.
  - Pulse is high in the following cycle.
  - FSM enters FETCH at the next edge.
- A raw glitch shorter than `DEBOUNCE_CYCLES` synced samples produces no pulse.
- Holding a button gives exactly one pulse. Release needs `DEBOUNCE_CYCLES` stable low samples before a new press is accepted.
- Browse throughput is one word per 2+`MEM_LATENCY` cycles after a pulse.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `NUM_WORDS`=4, `MEM_LATENCY`=1, `BASE_ADDR`=4, and memory word i at 4+4i = 16'hA000+i.

1. Assert `done` 1 cycle → one `mem_rd_en` pulse at `mem_addr`=4. Two cycles later, `disp_value`=16'hA000, `disp_valid`=1, `cur_index`=0, `sel_active`=1. `done` dropped afterwards changes nothing.
2. Four clean next presses, each held 10 cycles and released 10 cycles → addresses 8, 12, 16, 4 in order. `disp_value` steps A001, A002, A003, A000. Exactly 4 `mem_rd_en` pulses.
3. Prev press from index 0 → `mem_addr`=16, `disp_value`=16'hA003, `cur_index`=3.
4. `btn_next` glitch high for 3 cycles, plus a press during IDLE before `done` → no `mem_rd_en`, index unchanged. Next and prev raised on the same cycle and held → no fetch.
5. Assert `reset` in the WAIT cycle → all outputs return to reset values immediately, and no capture occurs. After release, `done` restarts from address 4.
6. Hold `btn_next` for 40 cycles → exactly one fetch, to address 8.

Source files
------------

// File: rtl/result_browser.sv
// Post-execution result viewer: after the CPU finishes, fetches result words from data
// memory and presents the low 16 bits to the scan driver, browsing with next/prev buttons.

module result_browser_btn #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_pulse
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             r_meta;
  logic             r_sync;
  logic             r_db;
  logic             r_db_d;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchronizer for the raw asynchronous button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Debouncer: accept a level change only after it has been stable long enough
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db  <= 1'b0;
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_sync == r_db) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db  <= r_sync;
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Delayed debounced level for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_db_d <= 1'b0;
    else       r_db_d <= r_db;
  end

  assign o_pulse = r_db & ~r_db_d;
endmodule

module result_browser #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0004,
  parameter int          NUM_WORDS       = 16,
  parameter int          MEM_LATENCY     = 1,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          IDX_W           = $clog2(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_done,
  input  logic             i_btn_next,
  input  logic             i_btn_prev,
  input  logic [31:0]      i_mem_rd_data,
  output logic             o_mem_rd_en,
  output logic [31:0]      o_mem_addr,
  output logic             o_sel_active,
  output logic [15:0]      o_disp_value,
  output logic             o_disp_valid,
  output logic [IDX_W-1:0] o_cur_index
);
  localparam int LAT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_WAIT  = 2'b10,
    S_SHOW  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic [LAT_W-1:0] r_lat_cnt;
  logic             w_lat_done;
  logic             w_capture;
  logic [31:0]      w_addr_next;
  logic             w_next_pulse;
  logic             w_prev_pulse;
  logic             w_unused_hi;

  logic             r_mem_rd_en;
  logic [31:0]      r_mem_addr;
  logic             r_sel_active;
  logic [15:0]      r_disp_value;
  logic             r_disp_valid;
  logic [IDX_W-1:0] r_cur_index;

  result_browser_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (i_btn_next),
    .o_pulse (w_next_pulse)
  );

  result_browser_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_prev (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (i_btn_prev),
    .o_pulse (w_prev_pulse)
  );

  assign w_unused_hi = ^i_mem_rd_data[31:16];
  assign w_lat_done  = (r_lat_cnt == LAT_W'(MEM_LATENCY - 1));
  assign w_addr_next = BASE_ADDR + {{(30 - IDX_W){1'b0}}, w_idx_next, 2'b00};

  // Next-state, target index and capture decision
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_done) begin
          w_state_next = S_FETCH;
          w_idx_next   = {IDX_W{1'b0}};
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_lat_done) begin
          w_state_next = S_SHOW;
          w_capture    = 1'b1;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_SHOW: begin
        // Coincident next/prev pulses cancel each other
        if (w_next_pulse && !w_prev_pulse) begin
          w_state_next = S_FETCH;
          w_idx_next   = (r_idx == IDX_W'(NUM_WORDS - 1)) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
        end else if (w_prev_pulse && !w_next_pulse) begin
          w_state_next = S_FETCH;
          w_idx_next   = (r_idx == {IDX_W{1'b0}}) ? IDX_W'(NUM_WORDS - 1) : r_idx - IDX_W'(1);
        end else begin
          w_state_next = S_SHOW;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, index and latency counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= {IDX_W{1'b0}};
      r_lat_cnt <= {LAT_W{1'b0}};
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_lat_cnt <= (r_state == S_WAIT && !w_lat_done) ? r_lat_cnt + LAT_W'(1) : {LAT_W{1'b0}};
    end
  end

  // Registered outputs; address and display hold between fetches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_rd_en  <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_sel_active <= 1'b0;
      r_disp_value <= 16'h0000;
      r_disp_valid <= 1'b0;
      r_cur_index  <= {IDX_W{1'b0}};
    end else begin
      r_mem_rd_en <= (w_state_next == S_FETCH);
      if (w_state_next == S_FETCH) r_mem_addr <= w_addr_next;
      if (w_state_next != S_IDLE) r_sel_active <= 1'b1;
      if (w_capture) begin
        r_disp_value <= i_mem_rd_data[15:0];
        r_disp_valid <= 1'b1;
        r_cur_index  <= r_idx;
      end
    end
  end

  assign o_mem_rd_en  = r_mem_rd_en;
  assign o_mem_addr   = r_mem_addr;
  assign o_sel_active = r_sel_active;
  assign o_disp_value = r_disp_value;
  assign o_disp_valid = r_disp_valid;
  assign o_cur_index  = r_cur_index;
endmodule
